matrix_loader: RTL
==================

// Module: matrix_loader
// PURPOSE
//   Write-side front end for the matrix data memory. Accepts a stream of 32-bit
//   elements over a valid/ready handshake and packs them row-major into a
//   WIDTH x WIDTH staging buffer. Once all elements are in, it commits the whole
//   matrix to the memory write port (write_enable/write/write_data) in one cycle.
// PARAMETERS
//   WIDTH   2**`WIDTH_BIT  matrix dimension (rows = cols = WIDTH), power of two
//   IDX_W   `INDEX_BIT     width of matrix slot index in data memory
// PORTS
//   CLK        in   1                  rising-edge clock
//   RST_N      in   1                  asynchronous reset, active-low
//   start      in   1                  begin loading a matrix into slot dest_idx
//   abort      in   1                  cancel an in-progress load, no commit
//   dest_idx   in   IDX_W              target memory slot, sampled on accepted start
//   in_valid   in   1                  in_data holds a valid element
//   in_data    in   32                 element value
//   in_ready   out  1                  loader accepts an element this cycle
//   mem_we     out  1                  write strobe to data memory
//   mem_waddr  out  IDX_W              slot index to data memory
//   mem_wdata  out  [0:WIDTH-1][0:WIDTH-1][31:0]  packed matrix to data memory
//   busy       out  1                  high in FILL and COMMIT
//   done       out  1                  one-cycle pulse, coincident with mem_we
// BEHAVIOUR
//   - Reset (RST_N low, async): state=IDLE, buffer all zero, row=col=0,
//     mem_waddr=0, mem_we=0, in_ready=0, busy=0, done=0.
//   - States: IDLE -> FILL -> COMMIT -> IDLE.
//   - IDLE: in_ready=0. start=1 -> latch dest_idx into mem_waddr, row=col=0,
//     go FILL next cycle. Buffer is not cleared (every element is overwritten).
//   - FILL: in_ready=1. Transfer = in_valid & in_ready; writes buffer[row][col].
//     col increments; at col=WIDTH-1 col wraps to 0 and row increments.
//     Transfer at row=col=WIDTH-1 -> COMMIT next cycle; in_ready=0 from then.
//   - COMMIT: exactly one cycle; mem_we=1, done=1; then IDLE.
//     Latency: commit is the cycle after the last transfer.
//   - mem_wdata is the buffer register, driven continuously; only valid for
//     downstream use while mem_we=1.
//   - start while busy: ignored (no relatch of dest_idx, no counter reset).
//   - abort in FILL: return to IDLE next cycle, counters to 0, no mem_we/done;
//     a transfer coincident with abort is discarded. abort has priority over the
//     final transfer. abort in IDLE or COMMIT: ignored (commit always completes).
//   - start and abort both high in IDLE: start wins.
//   - in_valid stalls (low) in FILL: state and counters hold indefinitely.
//   - Reset mid-FILL/COMMIT: immediate return to reset values; a partially
//     filled matrix is never written.
// CONFIGURATION
//   MATRIX_LOADER_TRANSPOSE_EN
//     defined:   elements stored column-major: transfer writes buffer[col][row]
//                with the same counter sequence, so memory receives the
//                transpose of the row-major stream.
//     undefined: row-major storage as above. No port or timing differences.
// TESTING  (WIDTH=4, IDX_W=3 unless stated)
//   1 Reset: RST_N low mid-cycle -> all outputs 0 immediately, buffer zero.
//   2 start, dest_idx=5, stream 1..16 back-to-back -> mem_we/done high one cycle
//     after 16th transfer, mem_waddr=5, mem_wdata[0][0]=1, [0][3]=4, [3][3]=16.
//   3 Same stream with in_valid toggled every other cycle -> identical commit,
//     16 transfers, no extra or lost elements.
//   4 abort after 7 transfers -> IDLE, no mem_we; new start dest_idx=2, stream
//     100..115 -> commit to slot 2, [0][0]=100, [3][3]=115.
//   5 start pulsed again during FILL with dest_idx=6 -> ignored, commit to
//     original slot, counters unaffected.
//   6 With MATRIX_LOADER_TRANSPOSE_EN, stream 1..16 -> [0][1]=5, [1][0]=2,
//     [3][0]=4, [3][3]=16.

Source files
------------

// File: rtl/matrix_loader.sv
// Streams WIDTH*WIDTH 32-bit elements into a staging buffer and commits the whole matrix in one write.
// Optional MATRIX_LOADER_TRANSPOSE_EN stores elements column-major so memory receives the transpose.
module matrix_loader #(
    parameter int WIDTH_BIT = 2,
    parameter int WIDTH     = 2 ** WIDTH_BIT,
    parameter int IDX_W     = 3
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic                                  start_i,
    input  logic                                  abort_i,
    input  logic [IDX_W-1:0]                      dest_idx_i,
    input  logic                                  in_valid_i,
    input  logic [31:0]                           in_data_i,
    output logic                                  in_ready_o,
    output logic                                  mem_we_o,
    output logic [IDX_W-1:0]                      mem_waddr_o,
    output logic [0:WIDTH-1][0:WIDTH-1][31:0]     mem_wdata_o,
    output logic                                  busy_o,
    output logic                                  done_o
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COMMIT
    } state_t;

    localparam logic [WIDTH_BIT-1:0] CNT_MAX = '1;
    localparam logic [WIDTH_BIT-1:0] CNT_ONE = {{(WIDTH_BIT-1){1'b0}}, 1'b1};

    state_t                               state_q;
    logic [WIDTH_BIT-1:0]                 row_q;
    logic [WIDTH_BIT-1:0]                 col_q;
    logic [0:WIDTH-1][0:WIDTH-1][31:0]    buf_q;
    logic [IDX_W-1:0]                     waddr_q;
    logic                                 in_ready_q;
    logic                                 mem_we_q;
    logic                                 busy_q;
    logic                                 done_q;
    logic                                 last_elem;

    assign last_elem = (row_q == CNT_MAX) && (col_q == CNT_MAX);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            buf_q      <= '0;
            waddr_q    <= '0;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q    <= FILL;
                        waddr_q    <= dest_idx_i;
                        row_q      <= '0;
                        col_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                FILL: begin
                    // Abort outranks any coincident transfer, including the final one.
                    if (abort_i) begin
                        state_q    <= IDLE;
                        row_q      <= '0;
                        col_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (in_valid_i && in_ready_q) begin
`ifdef MATRIX_LOADER_TRANSPOSE_EN
                        buf_q[col_q][row_q] <= in_data_i;
`else
                        buf_q[row_q][col_q] <= in_data_i;
`endif
                        col_q <= col_q + CNT_ONE;
                        if (col_q == CNT_MAX) begin
                            row_q <= row_q + CNT_ONE;
                        end
                        if (last_elem) begin
                            state_q    <= COMMIT;
                            in_ready_q <= 1'b0;
                            mem_we_q   <= 1'b1;
                            done_q     <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    state_q  <= IDLE;
                    mem_we_q <= 1'b0;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    mem_we_q   <= 1'b0;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign mem_we_o    = mem_we_q;
    assign mem_waddr_o = waddr_q;
    assign mem_wdata_o = buf_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
